// File: rtl/note_row_reader.sv
// Reader for the 4-lane note-pattern memory: walks addresses, prefetches the next
// row and presents it on each beat, with optional looping for practice mode.
module note_row_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN    = 64
) (
  input  logic              C,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              beat,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_data,
  output logic [3:0]        row,
  output logic              row_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned ROW_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  prefetch_q, prefetch_d;
  logic              row_valid_q, row_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;

  // Next-state and datapath; stop outranks beat handling, which outranks start.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    prefetch_d  = prefetch_q;
    row_valid_d = 1'b0;
    overrun_d   = overrun_q;
    pending_d   = pending_q;

    if (stop) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      row_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_FETCH;
            addr_d    = '0;
            overrun_d = 1'b0;
            pending_d = 1'b0;
          end
        end
        S_FETCH, S_LATCH: begin
          state_d = (state_q == S_FETCH) ? S_LATCH : S_HOLD;
          if (state_q == S_LATCH) begin
            prefetch_d = mem_data;
          end
          // A second beat before the row is ready cannot be queued.
          if (beat) begin
            if (pending_q) begin
              overrun_d = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (beat || pending_q) begin
            row_d       = prefetch_q;
            row_valid_d = 1'b1;
            pending_d   = 1'b0;
            if (beat && pending_q) begin
              overrun_d = 1'b1;
            end
            if (addr_q == LAST_ADDR) begin
              if (loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge C) begin
    if (clr) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      row_q       <= '0;
      prefetch_q  <= '0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      prefetch_q  <= prefetch_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
    end
  end

  assign mem_addr  = addr_q;
  assign row       = row_q;
  assign row_valid = row_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_note_row_reader.sv
// Scoreboard bench: two readers (LEN=4 one-shot, LEN=3 looping) with
// synchronous memory models; expected rows are queued at each beat.
module tb_note_row_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reader A: LEN=4
  logic       a_clr = 1'b1, a_start = 1'b0, a_stop = 1'b0, a_loop = 1'b0, a_beat = 1'b0;
  logic [5:0] a_mem_addr;
  logic [3:0] a_mem_data = 4'h0;
  logic [3:0] a_row;
  logic       a_row_valid, a_busy, a_done, a_overrun;
  logic [3:0] mem_a [0:63];
  logic [3:0] q_a [$];

  // Reader B: LEN=3
  logic       b_clr = 1'b1, b_start = 1'b0, b_stop = 1'b0, b_loop = 1'b0, b_beat = 1'b0;
  logic [5:0] b_mem_addr;
  logic [3:0] b_mem_data = 4'h0;
  logic [3:0] b_row;
  logic       b_row_valid, b_busy, b_done, b_overrun;
  logic [3:0] mem_b [0:63];
  logic [3:0] q_b [$];

  note_row_reader #(.ADDR_W(6), .LEN(4)) u_a (
    .C(clk), .clr(a_clr), .start(a_start), .stop(a_stop), .loop_en(a_loop), .beat(a_beat),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .row(a_row), .row_valid(a_row_valid),
    .busy(a_busy), .done(a_done), .overrun(a_overrun)
  );

  note_row_reader #(.ADDR_W(6), .LEN(3)) u_b (
    .C(clk), .clr(b_clr), .start(b_start), .stop(b_stop), .loop_en(b_loop), .beat(b_beat),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .row(b_row), .row_valid(b_row_valid),
    .busy(b_busy), .done(b_done), .overrun(b_overrun)
  );

  // Synchronous pattern memories: data one cycle after the address.
  always @(posedge clk) begin
    a_mem_data <= mem_a[a_mem_addr];
    b_mem_data <= mem_b[b_mem_addr];
  end

  // Monitor: pop and compare on every row_valid, and flag back-to-back pulses.
  logic a_rv_prev = 1'b0, b_rv_prev = 1'b0;
  always @(negedge clk) begin
    if (a_row_valid) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_row_unexpected: got row %0h with no expected row queued", a_row);
      end else begin
        logic [3:0] e;
        e = q_a.pop_front();
        if (a_row !== e || a_rv_prev) begin
          n_fail++;
          $display("FAIL a_row: got %0h (prev valid %0b) expected %0h (prev valid 0)", a_row, a_rv_prev, e);
        end
      end
    end
    if (b_row_valid) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_row_unexpected: got row %0h with no expected row queued", b_row);
      end else begin
        logic [3:0] e;
        e = q_b.pop_front();
        if (b_row !== e || b_rv_prev) begin
          n_fail++;
          $display("FAIL b_row: got %0h (prev valid %0b) expected %0h (prev valid 0)", b_row, b_rv_prev, e);
        end
      end
    end
    a_rv_prev <= a_row_valid;
    b_rv_prev <= b_row_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rows_b [3];
    rows_b = '{4'hA, 4'h5, 4'hF};
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 4'h0;
      mem_b[i] = 4'h0;
    end
    mem_a[0] = 4'h1; mem_a[1] = 4'h2; mem_a[2] = 4'h4; mem_a[3] = 4'h8;
    for (int i = 0; i < 3; i++) mem_b[i] = rows_b[i];

    // Reset
    tick(3);
    a_clr = 1'b0;
    b_clr = 1'b0;
    check("rst_row", 32'(a_row), 32'h0);
    check("rst_row_valid", 32'(a_row_valid), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_done", 32'(a_done), 32'h0);
    check("rst_overrun", 32'(a_overrun), 32'h0);
    check("rst_addr", 32'(a_mem_addr), 32'h0);

    // Basic read: beats every 5 cycles
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    check("basic_busy", 32'(a_busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(4);
      a_beat = 1'b1;
      q_a.push_back(mem_a[i]);
      tick(1);
      a_beat = 1'b0;
      check("basic_done_level", 32'(a_done), (i == 3) ? 32'h1 : 32'h0);
    end
    tick(3);
    check("basic_done_hold", 32'(a_done), 32'h1);
    check("basic_busy_done", 32'(a_busy), 32'h0);
    check("basic_addr_last", 32'(a_mem_addr), 32'h3);
    check("basic_row_last", 32'(a_row), 32'h8);
    check("basic_all_rows", 32'(q_a.size()), 32'h0);

    // Restart from DONE, beat 3 cycles after start
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    check("restart_done_drop", 32'(a_done), 32'h0);
    check("restart_busy", 32'(a_busy), 32'h1);
    check("restart_row_kept", 32'(a_row), 32'h8);
    tick(2);
    check("restart_row_before_beat", 32'(a_row), 32'h8);
    a_beat = 1'b1;
    q_a.push_back(4'h1);
    tick(1);
    a_beat = 1'b0;
    check("latency3_row", 32'(a_row), 32'h1);
    a_stop = 1'b1;
    tick(1);
    a_stop = 1'b0;

    // Beat one cycle after start is held pending
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    a_beat = 1'b1;
    q_a.push_back(4'h1);
    tick(1);
    a_beat = 1'b0;
    tick(1);
    check("pending_no_early_valid", 32'(a_row_valid), 32'h0);
    check("pending_no_early_row", 32'(a_row), 32'h0);
    tick(1);
    check("pending_row", 32'(a_row), 32'h1);
    check("pending_no_overrun", 32'(a_overrun), 32'h0);
    a_stop = 1'b1;
    tick(1);
    a_stop = 1'b0;

    // Overrun: two beats in one FETCH/LATCH window
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    a_beat = 1'b1;
    q_a.push_back(4'h1);
    tick(2);
    a_beat = 1'b0;
    check("overrun_set", 32'(a_overrun), 32'h1);
    tick(6);
    check("overrun_sticky", 32'(a_overrun), 32'h1);
    check("overrun_one_advance_row", 32'(a_row), 32'h1);
    check("overrun_one_advance_addr", 32'(a_mem_addr), 32'h1);
    a_stop = 1'b1;
    tick(1);
    a_stop = 1'b0;
    check("stop_keeps_overrun", 32'(a_overrun), 32'h1);
    check("stop_row_zero", 32'(a_row), 32'h0);
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    check("start_clears_overrun", 32'(a_overrun), 32'h0);

    // clr mid-FETCH
    tick(2);
    a_beat = 1'b1;
    q_a.push_back(4'h1);
    tick(1);
    a_beat = 1'b0;
    a_clr = 1'b1;
    tick(1);
    a_clr = 1'b0;
    check("clr_row", 32'(a_row), 32'h0);
    check("clr_addr", 32'(a_mem_addr), 32'h0);
    check("clr_busy", 32'(a_busy), 32'h0);
    check("clr_row_valid", 32'(a_row_valid), 32'h0);
    check("clr_done", 32'(a_done), 32'h0);

    // start and stop together stay in IDLE
    a_start = 1'b1;
    a_stop = 1'b1;
    tick(1);
    a_start = 1'b0;
    a_stop = 1'b0;
    check("start_stop_idle", 32'(a_busy), 32'h0);
    tick(3);
    check("start_stop_idle_later", 32'(a_busy), 32'h0);

    // Loop mode on LEN=3
    b_loop = 1'b1;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(4);
      b_beat = 1'b1;
      q_b.push_back(rows_b[i % 3]);
      tick(1);
      b_beat = 1'b0;
      check("loop_no_done", 32'(b_done), 32'h0);
      check("loop_addr_wrap", 32'(b_mem_addr), 32'((i + 1) % 3));
    end
    tick(4);
    b_beat = 1'b1;
    q_b.push_back(4'h5);
    tick(1);
    b_beat = 1'b0;
    tick(2);
    check("abort_row_before", 32'(b_row), 32'h5);
    b_stop = 1'b1;
    tick(1);
    b_stop = 1'b0;
    check("abort_row", 32'(b_row), 32'h0);
    check("abort_busy", 32'(b_busy), 32'h0);
    check("abort_addr", 32'(b_mem_addr), 32'h0);

    tick(5);
    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
